mul_sequencer: RTL and testbench
================================

// Module: mul_sequencer
// PURPOSE
//  Iterative 64-bit MUL unit for the EX stage that time-shares the existing ALU
//  instead of instantiating its own adder. Shift-add algorithm: one multiplier bit
//  per cycle, with early exit when the remaining multiplier bits are zero.
//  While the sequence runs, the block requests the ALU and stalls the pipeline.
//  Result is the low WIDTH bits of op_a*op_b (ARMv8 MUL semantics, modulo 2^WIDTH).
// PARAMETERS
//  WIDTH     64    operand/result width; must match ALU datapath width
//  CNT_W     7     iteration counter width; must satisfy 2^CNT_W > WIDTH
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high reset
//  start        in   1      request a multiply; sampled only in IDLE
//  op_a         in   WIDTH  multiplicand, latched on accepted start
//  op_b         in   WIDTH  multiplier, latched on accepted start
//  busy         out  1      high in RUN and DONE; drives pipeline stall
//  done         out  1      one-cycle pulse; result valid in this cycle
//  result       out  WIDTH  product; holds its value until the next accepted start
//  alu_req      out  1      high in RUN only; EX mux then routes alu_* to the ALU
//  alu_in1      out  WIDTH  ALU operand 1 = partial product P
//  alu_in2      out  WIDTH  ALU operand 2 = Q[0] ? M : 0
//  alu_control  out  4      4'b0010 (add) in RUN, 4'b0000 otherwise
//  alu_out      in   WIDTH  ALU sum, combinational in the same cycle
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, alu_req=0, result=0, P=M=Q=0, cnt=0.
//   Reset wins over every other event, including mid-RUN; partial work is discarded.
//  Internal regs: P (partial product), M (shifted multiplicand), Q (shifted
//   multiplier), cnt (iteration count).
//  States:
//   IDLE: busy=0. If start=1: P<=0, M<=op_a, Q<=op_b, cnt<=0, go to RUN.
//   RUN: alu_req=1, busy=1.
//    Each cycle: P<=alu_out; M<=M<<1 (MSB dropped); Q<=Q>>1; cnt<=cnt+1.
//    Go to DONE if (Q>>1)==0 or cnt==WIDTH-1; otherwise stay in RUN.
//   DONE: done=1, busy=1, result=P. Go to IDLE unconditionally.
//  Latency: start accepted in cycle t -> RUN cycles t+1..t+n -> done in cycle t+n+1.
//   n = max(1, position of the highest set bit of op_b, plus 1); n<=WIDTH.
//  start is ignored in RUN and DONE. It is not queued; the requester holds it until
//   busy=0. A start in the cycle after done is accepted.
//  Operand changes after acceptance have no effect.
//  Arithmetic is modulo 2^WIDTH; carry-out and alu_zero are ignored.
//  result is registered. It updates only on entry to DONE and otherwise keeps its
//   value, including through a reset-free IDLE.
//  alu_in1/alu_in2 are 0 when alu_req=0.
// TESTING
//  T1 op_a=3, op_b=5, start at t -> alu_req high t+1..t+3, done at t+4,
//     result=15, busy low at t+5.
//  T2 op_a=0x1234, op_b=0 -> one RUN cycle, done at t+2, result=0.
//  T3 op_a=op_b=64'hFFFF_FFFF_FFFF_FFFF -> 64 RUN cycles, done at t+65, result=1.
//  T4 start repeatedly asserted during RUN with other operands -> ignored;
//     7*9 gives result=63.
//  T5 reset asserted 2 cycles into a 64-iteration run -> next cycle IDLE, busy=0,
//     result=0, alu_req=0; a new 6*7 then completes with 42.
//  T6 every cycle: alu_control==4'b0010 iff alu_req; busy==(state!=IDLE);
//     done never asserted on 2 consecutive cycles.

Source files
------------

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_sequencer
// Brief    : Iterative shift-add multiplier that borrows the EX-stage ALU
//            for its additions, one multiplier bit per cycle, early exit.
// Revision : 1.0 - initial release
// ============================================================================
module mul_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_req,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       C_ALU_ADD = 4'b0010;

    state_t           r_state;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_alu_req;
    logic [WIDTH-1:0] r_result;

    logic [WIDTH-1:0] w_q_next;
    logic             w_last;

    assign w_q_next = r_q >> 1;
    // Stop once no set multiplier bits remain; the count bound is a backstop.
    assign w_last   = (w_q_next == '0) || (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_p       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_alu_req <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_p       <= '0;
                        r_m       <= op_a;
                        r_q       <= op_b;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_alu_req <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_p   <= alu_out;
                    r_m   <= r_m << 1;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result  <= alu_out;
                        r_done    <= 1'b1;
                        r_alu_req <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_alu_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign alu_req     = r_alu_req;
    assign alu_in1     = r_alu_req ? r_p : '0;
    assign alu_in2     = (r_alu_req && r_q[0]) ? r_m : '0;
    assign alu_control = r_alu_req ? C_ALU_ADD : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_sequencer
// Brief    : Directed-vector bench for mul_sequencer with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        alu_req;
    logic [63:0] alu_in1;
    logic [63:0] alu_in2;
    logic [3:0]  alu_control;
    logic [63:0] alu_out;

    int n_vec = 0;
    int n_err = 0;
    logic prev_done = 1'b0;

    mul_sequencer #(.WIDTH(64), .CNT_W(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .alu_req     (alu_req),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .alu_out     (alu_out)
    );

    assign alu_out = alu_in1 + alu_in2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle-by-cycle invariants on the handshake and ALU interface.
    always @(negedge clk) begin
        check("ctl_vs_req", {60'd0, alu_control}, alu_req ? 64'd2 : 64'd0);
        check("busy_vs_state", {63'd0, busy}, {63'd0, alu_req | done});
        check("done_twice", {63'd0, done & prev_done}, 64'd0);
        if (!alu_req)
            check("alu_in_idle", alu_in1 | alu_in2, 64'd0);
        prev_done <= done;
    end

    task automatic run_mul(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int exp_n, input bit hold);
        int  runs = 0;
        int  t    = 0;
        bit  seen = 0;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            op_a = ~a;
            op_b = b ^ 64'h5;
        end else begin
            start = 1'b0;
        end
        while (!seen && t < 200) begin
            if (done) begin
                seen = 1;
            end else begin
                if (alu_req) runs++;
                @(negedge clk);
                t++;
            end
        end
        start = 1'b0;
        check({tag, "_done"}, {63'd0, seen}, 64'd1);
        check({tag, "_runs"}, 64'(runs), 64'(exp_n));
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd1);
        @(negedge clk);
        check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        check({tag, "_result_hold"}, result, exp);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_req", {63'd0, alu_req}, 64'd0);
        check("rst_result", result, 64'd0);
        reset = 1'b0;

        run_mul("t1_3x5", 64'd3, 64'd5, 64'd15, 3, 0);
        repeat (3) @(negedge clk);
        check("t1_idle_hold", result, 64'd15);
        run_mul("t2_x0", 64'h1234, 64'd0, 64'd0, 1, 0);
        run_mul("t3_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64, 0);
        run_mul("t4_7x9", 64'd7, 64'd9, 64'd63, 4, 1);
        run_mul("wrap", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 2, 0);
        run_mul("w32", 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32, 0);
        run_mul("msb", 64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64, 0);

        // Abort a long run with reset two cycles in.
        @(negedge clk);
        op_a  = 64'hFFFF_FFFF_FFFF_FFFF;
        op_b  = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t5_running", {63'd0, alu_req}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_busy", {63'd0, busy}, 64'd0);
        check("t5_req", {63'd0, alu_req}, 64'd0);
        check("t5_result", result, 64'd0);
        reset = 1'b0;
        run_mul("t5_6x7", 64'd6, 64'd7, 64'd42, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
